// File: rtl/i2s_tx.sv
// I2S serialiser: one-entry s_valid/s_ready pair buffer, MSB first one sclk after each lrck edge; I2S_TX_REPEAT_EN replays last pair on underflow.
// Latency: MSB on sdin 2*SCLK_HALF clk after the lrck edge; s_ready drops while a pair waits, frees the cycle after the left-frame load.
module i2s_tx #(
  parameter int DATA_W    = 16,
  parameter int SCLK_HALF = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lrck,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              sclk,
  output logic              sdin,
  output logic              underflow
);

  localparam int CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} state_t;

  state_t            state, state_nxt;
  logic              lrck_q;
  logic              lrck_edge;
  logic [CW-1:0]     sclk_cnt;
  logic              sclk_tc;
  logic              fall_ev;
  logic [BW-1:0]     bit_cnt;
  logic              last_bit;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] right_hold;
  logic              buf_full;
  logic [DATA_W-1:0] buf_left;
  logic [DATA_W-1:0] buf_right;
`ifdef I2S_TX_REPEAT_EN
  logic [DATA_W-1:0] last_left;
  logic [DATA_W-1:0] last_right;
`endif

  assign lrck_edge = (lrck != lrck_q);
  assign sclk_tc   = (sclk_cnt == CW'(SCLK_HALF - 1));
  assign fall_ev   = sclk_tc && sclk;
  assign last_bit  = (bit_cnt == BW'(DATA_W - 1));
  assign s_ready   = !buf_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Any lrck edge restarts the word, aborting one still in flight.
  always_comb begin
    state_nxt = state;
    if (lrck_edge) begin
      state_nxt = DELAY;
    end else begin
      case (state)
        DELAY:   if (fall_ev) state_nxt = SHIFT;
        SHIFT:   if (fall_ev && last_bit) state_nxt = PAD;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lrck_q     <= 1'b0;
      sclk       <= 1'b0;
      sclk_cnt   <= '0;
      sdin       <= 1'b0;
      underflow  <= 1'b0;
      bit_cnt    <= '0;
      shift      <= '0;
      right_hold <= '0;
      buf_full   <= 1'b0;
      buf_left   <= '0;
      buf_right  <= '0;
`ifdef I2S_TX_REPEAT_EN
      last_left  <= '0;
      last_right <= '0;
`endif
    end else begin
      lrck_q    <= lrck;
      underflow <= 1'b0;

      if (lrck_edge) begin
        sclk     <= 1'b0;
        sclk_cnt <= '0;
      end else if (sclk_tc) begin
        sclk     <= !sclk;
        sclk_cnt <= '0;
      end else begin
        sclk_cnt <= sclk_cnt + CW'(1);
      end

      // Fill and drain are exclusive: fill needs empty, drain needs full.
      if (s_valid && !buf_full) begin
        buf_left  <= s_left;
        buf_right <= s_right;
        buf_full  <= 1'b1;
      end

      if (lrck_edge) begin
        sdin    <= 1'b0;
        bit_cnt <= '0;
        if (!lrck) begin
          if (buf_full) begin
            shift      <= buf_left;
            right_hold <= buf_right;
            buf_full   <= 1'b0;
`ifdef I2S_TX_REPEAT_EN
            last_left  <= buf_left;
            last_right <= buf_right;
`endif
          end else begin
            underflow  <= 1'b1;
`ifdef I2S_TX_REPEAT_EN
            shift      <= last_left;
            right_hold <= last_right;
`else
            shift      <= '0;
            right_hold <= '0;
`endif
          end
        end else begin
          shift <= right_hold;
        end
      end else if (fall_ev) begin
        case (state)
          DELAY: begin
            sdin  <= shift[DATA_W-1];
            shift <= shift << 1;
          end
          SHIFT: begin
            if (last_bit) begin
              sdin <= 1'b0;
            end else begin
              sdin    <= shift[DATA_W-1];
              shift   <= shift << 1;
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
          default: sdin <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: frame-level reference model (buffer occupancy, per-frame word, bit timing by arithmetic).
module tb_i2s_tx;

  localparam int DW   = 16;
  localparam int HALF = 4;
  localparam int BITP = 2 * HALF;
  localparam int MINP = BITP * (DW + 1);

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          lrck = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_left = '0;
  logic [DW-1:0] s_right = '0;
  logic          sclk;
  logic          sdin;
  logic          underflow;

  int n_checks = 0;
  int n_errors = 0;

  pair_t         sendq[$];
  logic          m_lrck_q, m_full, m_active;
  logic [DW-1:0] m_left, m_right, m_cur, m_hold, m_last_l, m_last_r;
  int            m_k;
  logic          cur_lvl = 1'b0;

  i2s_tx #(.DATA_W(DW), .SCLK_HALF(HALF)) dut (
    .clk(clk), .rst(rst), .lrck(lrck), .s_valid(s_valid), .s_ready(s_ready),
    .s_left(s_left), .s_right(s_right), .sclk(sclk), .sdin(sdin), .underflow(underflow)
  );

  always #5 clk = !clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h (frame cycle %0d)", tag, got, exp, m_k);
    end
  endtask

  task automatic model_reset();
    m_lrck_q = 1'b0; m_full = 1'b0; m_active = 1'b0; m_k = 0;
    m_left = '0; m_right = '0; m_cur = '0; m_hold = '0; m_last_l = '0; m_last_r = '0;
  endtask

  function automatic logic exp_sdin();
    if (rst || !m_active || m_k < BITP || m_k >= MINP) return 1'b0;
    return m_cur[DW - (m_k / BITP)];
  endfunction

  // One clk cycle: predict the edge effects, advance, then compare all outputs.
  task automatic tick();
    logic acc, uf;
    acc = 1'b0;
    uf  = 1'b0;
    s_valid = (sendq.size() > 0) && !rst;
    if (s_valid) begin
      s_left  = sendq[0].l;
      s_right = sendq[0].r;
    end
    if (rst) begin
      model_reset();
    end else begin
      acc = s_valid && !m_full;
      if (lrck != m_lrck_q) begin
        m_lrck_q = lrck;
        m_active = 1'b1;
        m_k = 0;
        if (!lrck) begin
          if (m_full) begin
            m_cur = m_left; m_hold = m_right;
            m_last_l = m_left; m_last_r = m_right;
            m_full = 1'b0;
          end else begin
            uf = 1'b1;
`ifdef I2S_TX_REPEAT_EN
            m_cur = m_last_l; m_hold = m_last_r;
`else
            m_cur = '0; m_hold = '0;
`endif
          end
        end else begin
          m_cur = m_hold;
        end
      end else begin
        m_k++;
      end
      if (acc) begin
        m_full = 1'b1;
        m_left = s_left;
        m_right = s_right;
        void'(sendq.pop_front());
      end
    end
    @(posedge clk);
    #1;
    chk("sdin", {31'b0, sdin}, {31'b0, exp_sdin()});
    chk("underflow", {31'b0, underflow}, {31'b0, uf});
    chk("s_ready", {31'b0, s_ready}, {31'b0, !m_full});
    if (rst) chk("sclk_rst", {31'b0, sclk}, 32'd0);
    else if (m_active) chk("sclk", {31'b0, sclk}, ((m_k / HALF) % 2));
  endtask

  task automatic frame(input logic lvl, input int len);
    lrck = lvl;
    cur_lvl = lvl;
    repeat (len) tick();
  endtask

  task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
    pair_t p;
    p.l = l;
    p.r = r;
    sendq.push_back(p);
  endtask

  initial begin
    model_reset();
    // Reset held with lrck toggling.
    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 0) lrck = !lrck;
      tick();
    end
    lrck = 1'b0;
    tick();
    rst = 1'b0;
    repeat (6) tick();

    // Directed A55A / 8001, then an underflow frame pair.
    push(16'hA55A, 16'h8001);
    frame(1'b1, MINP);
    frame(1'b0, MINP);
    frame(1'b1, MINP);
    frame(1'b0, MINP);
    frame(1'b1, MINP);

    // Backpressure: P1 lands at the underflowing edge, P2 waits a full frame.
    push(DW'($urandom), DW'($urandom));
    push(DW'($urandom), DW'($urandom));
    frame(1'b0, MINP);
    frame(1'b1, MINP);
    frame(1'b0, MINP);
    frame(1'b1, MINP);
    frame(1'b0, MINP);
    frame(1'b1, MINP);

    // Early lrck edge aborting a word mid-flight.
    push(DW'($urandom), DW'($urandom));
    frame(1'b0, 70);
    frame(1'b1, MINP);

    // Randomised frames: lengths, early edges, occasional pushes.
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 1) push(DW'($urandom), DW'($urandom));
      if ($urandom_range(0, 3) == 0) frame(!cur_lvl, $urandom_range(10, MINP - 6));
      else                           frame(!cur_lvl, MINP + BITP * $urandom_range(0, 2));
    end

    // Drain, then async reset in the middle of an all-ones left word with the buffer full.
    if (cur_lvl == 1'b0) frame(1'b1, MINP);
    frame(1'b0, MINP);
    push(16'hFFFF, 16'hFFFF);
    push(DW'($urandom), DW'($urandom));
    frame(1'b1, MINP);
    frame(1'b0, 53);
    #2 rst = 1'b1;
    #1;
    chk("async_sclk", {31'b0, sclk}, 32'd0);
    chk("async_sdin", {31'b0, sdin}, 32'd0);
    chk("async_s_ready", {31'b0, s_ready}, 32'd1);
    chk("async_underflow", {31'b0, underflow}, 32'd0);
    sendq.delete();
    model_reset();
    tick();
    rst = 1'b0;
    repeat (20) tick();
    frame(1'b1, MINP);
    frame(1'b0, MINP);
    frame(1'b1, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
